// File: rtl/vend_pkg.sv
// Shared types and coin constants for the change dispenser.
package vend_pkg;

   typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;

   localparam logic [4:0] COIN_2_0 = 5'd4;
   localparam logic [4:0] COIN_1_0 = 5'd2;
   localparam logic [4:0] COIN_0_5 = 5'd1;

   localparam int IDX_2_0 = 2;
   localparam int IDX_1_0 = 1;
   localparam int IDX_0_5 = 0;

   // Greedy pick: largest available coin not exceeding the remainder, one-hot.
   function automatic logic [2:0] pick_coin(input logic [4:0] rem, input logic [2:0] avail);
      pick_coin = 3'b000;
      if (avail[IDX_2_0] && rem >= COIN_2_0)
         pick_coin[IDX_2_0] = 1'b1;
      else if (avail[IDX_1_0] && rem >= COIN_1_0)
         pick_coin[IDX_1_0] = 1'b1;
      else if (avail[IDX_0_5] && rem >= COIN_0_5)
         pick_coin[IDX_0_5] = 1'b1;
   endfunction

   function automatic logic [4:0] coin_value(input logic [2:0] sel);
      coin_value = 5'd0;
      if (sel[IDX_2_0])      coin_value = COIN_2_0;
      else if (sel[IDX_1_0]) coin_value = COIN_1_0;
      else if (sel[IDX_0_5]) coin_value = COIN_0_5;
   endfunction

endpackage

// File: rtl/pulse_timer.sv
// Down-counter for ejector pulse/gap timing; expire strobes on the last counted cycle.
module pulse_timer #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expire
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign expire = (cnt == W'(1));

endmodule

// File: rtl/change_dispenser.sv
// Coin change dispenser: greedy 2.0/1.0/0.5 ejection with timed pulses.
// Build option CHANGE_STOCK_EN enables per-coin stock counting, refill and empty flags.
module change_dispenser
   import vend_pkg::*;
#(
   parameter int PULSE_CYC  = 10000000,
   parameter int GAP_CYC    = 10000000,
   parameter int STOCK_INIT = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req,
   input  logic [4:0] amount,
   input  logic       refill,
   output logic       busy,
   output logic       done,
   output logic [4:0] shortfall,
   output logic [2:0] coin_out,
   output logic [2:0] empty
);

   localparam int MAXC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
   localparam int TW   = $clog2(MAXC + 1);

   state_t          state;
   logic [4:0]      remaining;
   logic [2:0]      avail;
   logic [2:0]      sel;
   logic            tmr_load;
   logic [TW-1:0]   tmr_val;
   logic            expire;

`ifdef CHANGE_STOCK_EN
   logic [4:0] stock [3];

   always_comb begin
      empty = 3'b000;
      for (int i = 0; i < 3; i++)
         empty[i] = (stock[i] == 5'd0);
   end
   assign avail = ~empty;
`else
   logic unused_refill;
   assign unused_refill = refill;
   assign empty = 3'b000;
   assign avail = 3'b111;
`endif

   assign sel = pick_coin(remaining, avail);

   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = TW'(PULSE_CYC);
      if (state == SELECT && sel != 3'b000) begin
         tmr_load = 1'b1;
      end else if (state == PULSE && expire) begin
         tmr_load = 1'b1;
         tmr_val  = TW'(GAP_CYC);
      end
   end

   pulse_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expire   (expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         coin_out  <= 3'b000;
         busy      <= 1'b0;
         done      <= 1'b0;
         shortfall <= 5'd0;
         remaining <= 5'd0;
`ifdef CHANGE_STOCK_EN
         for (int i = 0; i < 3; i++) stock[i] <= 5'(STOCK_INIT);
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  remaining <= amount;
                  shortfall <= 5'd0;
                  busy      <= 1'b1;
                  state     <= SELECT;
               end
`ifdef CHANGE_STOCK_EN
               else if (refill) begin
                  for (int i = 0; i < 3; i++) stock[i] <= 5'(STOCK_INIT);
               end
`endif
            end
            SELECT: begin
               // Selection never picks a coin worth more than remaining, so no underflow.
               if (sel != 3'b000) begin
                  remaining <= remaining - coin_value(sel);
                  coin_out  <= sel;
`ifdef CHANGE_STOCK_EN
                  for (int i = 0; i < 3; i++)
                     if (sel[i] && stock[i] != 5'd0) stock[i] <= stock[i] - 5'd1;
`endif
                  state <= PULSE;
               end else begin
                  state <= DONE;
               end
            end
            PULSE: begin
               if (expire) begin
                  coin_out <= 3'b000;
                  state    <= GAP;
               end
            end
            GAP: begin
               if (expire) state <= SELECT;
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
`ifdef CHANGE_STOCK_EN
               shortfall <= remaining;
`else
               shortfall <= 5'd0;
`endif
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: per-cycle timeline model plus literal pins.
module tb_change_dispenser;

   localparam int PC = 4;
   localparam int GC = 2;
   localparam int SI = 1;

   logic       clk, rst_n, req, refill;
   logic [4:0] amount;
   logic       busy, done;
   logic [4:0] shortfall;
   logic [2:0] coin_out, empty;

   change_dispenser #(.PULSE_CYC(PC), .GAP_CYC(GC), .STOCK_INIT(SI)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .amount(amount), .refill(refill),
      .busy(busy), .done(done), .shortfall(shortfall), .coin_out(coin_out), .empty(empty)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] coin;
      logic       busy;
      logic       done;
      logic [4:0] sf;
      logic [2:0] emp;
   } exp_t;

   exp_t       q[$];
   int         mstock[3];
   logic [4:0] m_short;
   logic [2:0] m_empty;
   int         nchecks = 0;
   int         nerr = 0;
   logic       chk_en;
   logic [2:0] prev_coin = 3'b000;
   int         seen[$];
   int         seen_len[$];

   task automatic check(input string nm, input int act, input int expv);
      nchecks++;
      if (act != expv) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
      end
   endtask

   function automatic logic [2:0] emp_now();
      logic [2:0] e;
      e = 3'b000;
`ifdef CHANGE_STOCK_EN
      for (int i = 0; i < 3; i++) e[i] = (mstock[i] == 0);
`endif
      return e;
   endfunction

   function automatic bit have(input int i);
`ifdef CHANGE_STOCK_EN
      return mstock[i] > 0;
`else
      return 1'b1;
`endif
   endfunction

   // Timeline after an accepted request: one select cycle, then per coin
   // PC high + GC low + select, then the done state, then the done pulse.
   function automatic void build(input int amt);
      int rem;
      int pick;
      rem = amt;
      q.push_back('{3'b000, 1'b1, 1'b0, 5'd0, emp_now()});
      forever begin
         pick = -1;
         for (int i = 2; i >= 0; i--)
            if (pick < 0 && have(i) && rem >= (1 << i)) pick = i;
         if (pick < 0) break;
         rem -= (1 << pick);
         mstock[pick] = mstock[pick] - 1;
         for (int k = 0; k < PC; k++)
            q.push_back('{3'(1 << pick), 1'b1, 1'b0, 5'd0, emp_now()});
         for (int k = 0; k < GC + 1; k++)
            q.push_back('{3'b000, 1'b1, 1'b0, 5'd0, emp_now()});
      end
      q.push_back('{3'b000, 1'b1, 1'b0, 5'd0, emp_now()});
`ifdef CHANGE_STOCK_EN
      q.push_back('{3'b000, 1'b0, 1'b1, 5'(rem), emp_now()});
`else
      q.push_back('{3'b000, 1'b0, 1'b1, 5'd0, emp_now()});
`endif
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 3; i++) mstock[i] = SI;
      m_short = 5'd0;
      m_empty = emp_now();
      q.delete();
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (chk_en) begin
         if (q.size() > 0) begin
            e = q.pop_front();
            m_short = e.sf;
            m_empty = e.emp;
         end else begin
            e = '{3'b000, 1'b0, 1'b0, m_short, m_empty};
         end
         check("coin_out", int'(coin_out), int'(e.coin));
         check("busy", int'(busy), int'(e.busy));
         check("done", int'(done), int'(e.done));
         check("shortfall", int'(shortfall), int'(e.sf));
         check("empty", int'(empty), int'(e.emp));
         if (coin_out != 3'b000 && prev_coin == 3'b000) begin
            seen.push_back(int'(coin_out));
            seen_len.push_back(1);
         end else if (coin_out != 3'b000 && seen_len.size() > 0) begin
            seen_len[seen_len.size()-1] = seen_len[seen_len.size()-1] + 1;
         end
         prev_coin = coin_out;
      end
   end

   task automatic do_req(input int amt);
      @(negedge clk);
      req = 1'b1;
      amount = amt[4:0];
      @(posedge clk);
      build(amt);
      @(negedge clk);
      req = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 1;
      while (!done && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      if (!done) check("done_timeout", 0, 1);
   endtask

   task automatic run(input int amt, output int lat);
      seen.delete();
      seen_len.delete();
      do_req(amt);
      wait_done(lat);
   endtask

   task automatic do_refill();
      @(negedge clk);
      refill = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 3; i++) mstock[i] = SI;
      m_empty = emp_now();
      @(negedge clk);
      refill = 1'b0;
   endtask

   task automatic pin_pulses(input int n, input int c0, input int c1, input int c2);
      check("pulse_count", seen.size(), n);
      if (seen.size() >= 3) begin
         check("pulse0", seen[0], c0);
         check("pulse1", seen[1], c1);
         check("pulse_last", seen[seen.size()-1], c2);
      end
      foreach (seen_len[i]) check("pulse_len", seen_len[i], PC);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int k;
      int n4;
      clk = 1'b0; rst_n = 1'b0; req = 1'b0; amount = 5'd0; refill = 1'b0; chk_en = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_coin", coin_out, 0);
      check("rst_short", shortfall, 0);
      check("rst_empty", empty, 0);
      rst_n = 1'b1;
      #1 chk_en = 1'b1;

      // 3.5 -> 2.0, 1.0, 0.5
      run(7, lat);
      pin_pulses(3, 4, 2, 1);
      check("sf_7", shortfall, 0);
`ifdef CHANGE_STOCK_EN
      check("empty_7", empty, 7);
`else
      check("empty_7", empty, 0);
`endif

      do_refill();
      run(0, lat);
      check("lat_0", lat, 3);
      check("pulses_0", seen.size(), 0);
      check("sf_0", shortfall, 0);

      run(12, lat);
`ifdef CHANGE_STOCK_EN
      pin_pulses(3, 4, 2, 1);
      check("sf_12", shortfall, 5);
`else
      pin_pulses(3, 4, 4, 4);
      check("sf_12", shortfall, 0);
`endif

      // req and refill during a refund are ignored
      do_refill();
      seen.delete(); seen_len.delete();
      do_req(3);
      repeat (3) @(negedge clk);
      req = 1'b1; amount = 5'd31; refill = 1'b1;
      @(negedge clk);
      req = 1'b0; refill = 1'b0;
      wait_done(lat);
      check("mid_pulses", seen.size(), 2);
`ifdef CHANGE_STOCK_EN
      check("mid_empty", empty, 3);
`endif
      repeat (3) @(negedge clk);
      check("mid_no_queue", busy, 0);
      do_refill();
      @(negedge clk);
      check("refill_empty", empty, 0);

      run(31, lat);
`ifdef CHANGE_STOCK_EN
      pin_pulses(3, 4, 2, 1);
      check("sf_31", shortfall, 24);
`else
      n4 = 0;
      foreach (seen[i]) if (seen[i] == 4) n4++;
      check("count_2_0", n4, 7);
      pin_pulses(9, 4, 4, 1);
      if (seen.size() == 9) check("pulse_1_0", seen[7], 2);
      check("sf_31", shortfall, 0);
      check("empty_31", empty, 0);
`endif

      // reset during the second cycle of a pulse
      do_refill();
      seen.delete(); seen_len.delete();
      do_req(7);
      k = 0;
      while (coin_out == 3'b000 && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("pulse_started", int'(coin_out != 3'b000), 1);
      @(posedge clk);
      #1;
      chk_en = 1'b0;
      rst_n = 1'b0;
      #1;
      check("arst_coin", coin_out, 0);
      check("arst_busy", busy, 0);
      check("arst_empty", empty, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      prev_coin = 3'b000;
      #1 chk_en = 1'b1;
      run(7, lat);
      pin_pulses(3, 4, 2, 1);
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule
